// File: rtl/bp_pkg.sv
// Shared encodings and the saturating-counter step for the branch predictor.
package bp_pkg;

  localparam logic [1:0] CNT_SNT   = 2'b00;
  localparam logic [1:0] CNT_WNT   = 2'b01;
  localparam logic [1:0] CNT_WT    = 2'b10;
  localparam logic [1:0] CNT_ST    = 2'b11;
  localparam logic [1:0] CNT_RESET = CNT_WNT;

  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == CNT_ST)  ? CNT_ST  : cnt + 2'd1;
    else       return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/pht_table.sv
// Pattern history table: 2^AW two-bit counters, async read, sync saturating update.
module pht_table
  import bp_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd_idx,
  output logic [1:0]    rd_cnt,
  input  logic          we,
  input  logic [AW-1:0] wr_idx,
  input  logic          wr_taken
);

  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0][1:0] mem_q, mem_d;

  // Read sees the stored value; a same-cycle write lands on the next edge.
  assign rd_cnt = mem_q[rd_idx];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wr_idx] = cnt_next(mem_q[wr_idx], wr_taken);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= {DEPTH{CNT_RESET}};
    else     mem_q <= mem_d;
  end

endmodule

// File: rtl/branch_predictor.sv
// Decode-stage direction predictor with Execute-stage training and succE report.
// Define BP_GSHARE_EN to XOR committed global history into the table index.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PHT_AW = 6,
  parameter int PC_W   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pcD,
  input  logic            branchD,
  input  logic            stallE,
  input  logic            flushE,
  input  logic            branchE,
  input  logic            actual_takeE,
  output logic            pred_takeD,
  output logic            succE
);

  logic [PHT_AW-1:0] idx_d;
  logic [1:0]        rd_cnt;
  logic              train;

  logic              ve_q, ve_d;
  logic [PHT_AW-1:0] idxe_q, idxe_d;
  logic              prede_q, prede_d;

  logic unused_pc;
  assign unused_pc = ^{pcD[PC_W-1:PHT_AW+2], pcD[1:0]};

  assign train = ve_q & branchE & ~stallE;

`ifdef BP_GSHARE_EN
  logic [PHT_AW-1:0] ghr_q, ghr_d, ghre_q, ghre_d;
  logic              unused_ghre;
  assign unused_ghre = ^ghre_q;

  assign idx_d = pcD[PHT_AW+1:2] ^ ghr_q;

  // History is committed at resolution, so it only advances with training.
  always_comb begin
    ghr_d = ghr_q;
    if (train) ghr_d = {ghr_q[PHT_AW-2:0], actual_takeE};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end
`else
  assign idx_d = pcD[PHT_AW+1:2];
`endif

  pht_table #(.AW(PHT_AW)) u_pht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx_d),
    .rd_cnt   (rd_cnt),
    .we       (train),
    .wr_idx   (idxe_q),
    .wr_taken (actual_takeE)
  );

  assign pred_takeD = branchD & rd_cnt[1];

  // Stall dominates flush so a held branch is neither lost nor duplicated.
  always_comb begin
    ve_d    = ve_q;
    idxe_d  = idxe_q;
    prede_d = prede_q;
`ifdef BP_GSHARE_EN
    ghre_d  = ghre_q;
`endif
    if (!stallE) begin
      if (flushE) begin
        ve_d    = 1'b0;
        idxe_d  = '0;
        prede_d = 1'b0;
`ifdef BP_GSHARE_EN
        ghre_d  = '0;
`endif
      end else begin
        ve_d    = branchD;
        idxe_d  = idx_d;
        prede_d = pred_takeD;
`ifdef BP_GSHARE_EN
        ghre_d  = ghr_q;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ve_q    <= 1'b0;
      idxe_q  <= '0;
      prede_q <= 1'b0;
`ifdef BP_GSHARE_EN
      ghre_q  <= '0;
`endif
    end else begin
      ve_q    <= ve_d;
      idxe_q  <= idxe_d;
      prede_q <= prede_d;
`ifdef BP_GSHARE_EN
      ghre_q  <= ghre_d;
`endif
    end
  end

  assign succE = ~(ve_q & branchE) | (prede_q == actual_takeE);

endmodule
